// File: rtl/keypad_pkg.sv
// Shared constants and state encodings for the decimal keypad debouncer.
package keypad_pkg;

    localparam int unsigned KEY_COUNT               = 10;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing asynchronous lines into the clk domain.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/decimal_keypad_debouncer.sv
// Debounces a 10-key decimal keypad into a sticky one-hot code with
// press-accepted and multi-key error pulses.
module decimal_keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KEY_COUNT-1:0] keys,
    output logic [KEY_COUNT-1:0] D,
    output logic                 key_valid,
    output logic                 key_held,
    output logic                 multi_err
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_COUNT-1:0] ks;
    logic [KEY_COUNT-1:0] cand, cand_n;
    logic [KEY_COUNT-1:0] d_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    state_t               state, state_n;
    logic                 one_hot;
    logic                 kv_n, kh_n, me_n;

    sync_2ff #(
        .WIDTH(KEY_COUNT)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (keys),
        .q  (ks)
    );

    assign one_hot = (cand != '0) && ((cand & (cand - KEY_COUNT'(1))) == '0);

    // Next-state and next-output logic; D only moves on an accepted one-hot press.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        d_n     = D;
        kv_n    = 1'b0;
        me_n    = 1'b0;
        case (state)
            IDLE: begin
                if (ks != '0) begin
                    cand_n  = ks;
                    cnt_n   = '0;
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (ks != cand) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = HELD;
                    if (one_hot) begin
                        d_n  = cand;
                        kv_n = 1'b1;
                    end else begin
                        me_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (ks == '0) begin
                    cnt_n   = '0;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (ks != '0) begin
                    cnt_n = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        kh_n = (state_n == HELD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            D         <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            D         <= d_n;
            key_valid <= kv_n;
            key_held  <= kh_n;
            multi_err <= me_n;
        end
    end

endmodule

// File: tb/tb_decimal_keypad_debouncer.sv
// Directed self-checking bench for decimal_keypad_debouncer (DEBOUNCE_CYCLES=4).
module tb_decimal_keypad_debouncer;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] keys;
    logic [9:0] D;
    logic       key_valid, key_held, multi_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int kv_cnt   = 0;
    int me_cnt   = 0;
    int kv_last  = -1;
    int me_last  = -1;
    int overlap  = 0;
    int too_long = 0;
    logic kv_prev = 1'b0;
    logic me_prev = 1'b0;

    decimal_keypad_debouncer #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .keys     (keys),
        .D        (D),
        .key_valid(key_valid),
        .key_held (key_held),
        .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock and sample outputs just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (key_valid) begin
            kv_cnt++;
            kv_last = cyc;
        end
        if (multi_err) begin
            me_cnt++;
            me_last = cyc;
        end
        if (key_valid && multi_err) overlap++;
        if ((key_valid && kv_prev) || (multi_err && me_prev)) too_long++;
        kv_prev = key_valid;
        me_prev = multi_err;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int t0;
        int kv0;
        int me0;
        logic [9:0] v;

        rst  = 1'b1;
        keys = '0;
        wait_cycles(3);
        check("rst_D", 32'(D), 32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_held", 32'(key_held), 32'h0);
        check("rst_multi_err", 32'(multi_err), 32'h0);
        rst = 1'b0;
        wait_cycles(3);

        // Clean press of key 3
        kv0  = kv_cnt;
        keys = 10'b0000001000;
        t0   = cyc;
        wait_cycles(20);
        check("clean_latency", 32'(kv_last - t0), 32'd7);
        check("clean_pulses", 32'(kv_cnt - kv0), 32'd1);
        check("clean_D", 32'(D), 32'h008);
        check("clean_held", 32'(key_held), 32'h1);
        check("clean_no_err", 32'(me_cnt), 32'd0);
        keys = '0;
        wait_cycles(12);
        check("release_held", 32'(key_held), 32'h0);
        check("release_D_sticky", 32'(D), 32'h008);

        // Bouncing key 2, then stable
        kv0 = kv_cnt;
        t0  = cyc;
        for (int i = 0; i < 10; i++) begin
            v = ((i % 4) < 2) ? 10'b0000000100 : 10'b0;
            if (v != keys) t0 = cyc;
            keys = v;
            tick();
        end
        wait_cycles(10);
        check("bounce_pulses", 32'(kv_cnt - kv0), 32'd1);
        check("bounce_latency", 32'(kv_last - t0), 32'd7);
        check("bounce_D", 32'(D), 32'h004);
        keys = '0;
        wait_cycles(12);

        // Two keys together
        kv0  = kv_cnt;
        me0  = me_cnt;
        keys = 10'b1000000001;
        t0   = cyc;
        wait_cycles(10);
        check("multi_err_pulses", 32'(me_cnt - me0), 32'd1);
        check("multi_err_latency", 32'(me_last - t0), 32'd7);
        check("multi_no_valid", 32'(kv_cnt - kv0), 32'd0);
        check("multi_D_kept", 32'(D), 32'h004);
        check("multi_held", 32'(key_held), 32'h1);
        keys = '0;
        wait_cycles(12);

        // Key 9 held, key 2 added, release, then key 2 alone
        kv0  = kv_cnt;
        me0  = me_cnt;
        keys = 10'b1000000000;
        wait_cycles(10);
        check("k9_pulses", 32'(kv_cnt - kv0), 32'd1);
        check("k9_D", 32'(D), 32'h200);
        keys = 10'b1000000100;
        wait_cycles(10);
        check("second_key_ignored", 32'(kv_cnt - kv0), 32'd1);
        check("second_key_no_err", 32'(me_cnt - me0), 32'd0);
        check("second_key_D", 32'(D), 32'h200);
        keys = '0;
        wait_cycles(12);
        keys = 10'b0000000100;
        t0   = cyc;
        wait_cycles(10);
        check("k2_pulses", 32'(kv_cnt - kv0), 32'd2);
        check("k2_latency", 32'(kv_last - t0), 32'd7);
        check("k2_D", 32'(D), 32'h004);
        keys = '0;
        wait_cycles(12);

        // Reset during debounce of key 5
        kv0  = kv_cnt;
        keys = 10'b0000100000;
        wait_cycles(5);
        rst = 1'b1;
        #1;
        check("midrst_D", 32'(D), 32'h0);
        check("midrst_valid", 32'(key_valid), 32'h0);
        check("midrst_held", 32'(key_held), 32'h0);
        check("midrst_no_pulse", 32'(kv_cnt - kv0), 32'd0);
        wait_cycles(2);
        check("inrst_D", 32'(D), 32'h0);
        rst = 1'b0;
        t0  = cyc;
        wait_cycles(10);
        check("postrst_latency", 32'(kv_last - t0), 32'd7);
        check("postrst_pulses", 32'(kv_cnt - kv0), 32'd1);
        check("postrst_D", 32'(D), 32'h020);

        check("valid_err_overlap", 32'(overlap), 32'd0);
        check("pulse_width", 32'(too_long), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decimal_keypad_debouncer.md
DECIMAL_KEYPAD_DEBOUNCER -- requirements
Module: decimal_keypad_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a press or release (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port keys, input, 10: raw asynchronous key lines, bit i = decimal key i, active-high.
REQ-005 SHALL have port D, output, 10: debounced one-hot key code, bit i = key i; feeds the decimal-to-BCD encoder directly.
REQ-006 SHALL have port key_valid, output, 1: one-cycle pulse when a new one-hot press is accepted.
REQ-007 SHALL have port key_held, output, 1: high while an accepted key, or a rejected multi-key, is held down.
REQ-008 SHALL have port multi_err, output, 1: one-cycle pulse when a debounced press has more than one bit set.

Function
REQ-009 SHALL pass keys through a 2-flop synchronizer; the FSM SHALL see only the synchronized value ks.
REQ-010 SHALL implement FSM states IDLE, DEBOUNCE, HELD and RELEASE, with a counter cnt of width clog2(DEBOUNCE_CYCLES).
REQ-011 IDLE: if ks != 0, SHALL latch cand <= ks, clear cnt and go to DEBOUNCE; otherwise SHALL stay in IDLE.
REQ-012 DEBOUNCE: if ks != cand, SHALL clear cnt and return to IDLE with no output change.
REQ-013 DEBOUNCE: if ks == cand and cnt < DEBOUNCE_CYCLES-1, SHALL increment cnt.
REQ-014 DEBOUNCE: if ks == cand and cnt == DEBOUNCE_CYCLES-1, and cand is one-hot:
  - D <= cand
  - key_valid pulses
  - go to HELD
REQ-015 DEBOUNCE: if ks == cand and cnt == DEBOUNCE_CYCLES-1, and cand has two or more bits set:
  - D unchanged
  - multi_err pulses
  - go to HELD
REQ-016 HELD: key_held SHALL be 1; when ks == 0, SHALL clear cnt and go to RELEASE.
REQ-017 RELEASE: if ks != 0, SHALL clear cnt and stay in RELEASE.
REQ-018 RELEASE: if ks == 0, SHALL increment cnt; at cnt == DEBOUNCE_CYCLES-1 SHALL go to IDLE.
REQ-019 D SHALL be sticky: it holds the last accepted code through release and idle until the next accepted press, so D is never multi-hot.
REQ-020 key_valid SHALL be registered 2+DEBOUNCE_CYCLES rising edges after the first edge that samples a stable new key value.
REQ-021 key_valid and multi_err SHALL never be high in the same cycle, and neither SHALL stay high for more than one cycle.
REQ-022 A second key pressed while in HELD SHALL be ignored until full release and a new debounce; no second key_valid.
REQ-023 Outputs D, key_valid, key_held and multi_err SHALL be driven from registers, with no combinational path from keys.

Reset
REQ-024 On rst=1, SHALL asynchronously set state=IDLE, cnt=0, cand=0, synchronizer flops=0, D=10'b0, key_valid=0, key_held=0, multi_err=0.
REQ-025 rst asserted mid-DEBOUNCE or mid-HELD SHALL abort the operation with no pulse; after deassertion, a still-held key SHALL be debounced afresh from IDLE.

Structure
REQ-026 Shared package keypad_pkg SHALL hold KEY_COUNT=10, the 2-bit state encodings (IDLE=0, DEBOUNCE=1, HELD=2, RELEASE=3) and the default DEBOUNCE_CYCLES.
REQ-027 The synchronizer SHALL be a sub-module sync_2ff, parameterized by width, instantiated once with width 10.
REQ-028 The one-hot check SHALL be combinational inside this module (cand != 0 and (cand & (cand-1)) == 0).

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Clean press: keys=10'b0000001000 held 20 cycles -> key_valid one pulse at edge 6 after first sample; D=10'b0000001000; key_held=1.
REQ-030 Bounce: keys toggles 0 <-> 10'b0000000100 every 2 cycles for 10 cycles, then stable -> exactly one key_valid, 6 edges after the last change; D=10'b0000000100.
REQ-031 Multi-key: keys=10'b1000000001 stable 10 cycles -> multi_err single pulse; key_valid stays 0; D keeps its prior value.
REQ-032 Hold then second key: press key 9, then add key 2 while held, release both, press key 2 -> key_valid once for 9 (D=10'b1000000000), then once for 2 (D=10'b0000000100) after release debounce.
REQ-033 Reset mid-debounce: key 5 pressed, rst pulsed at cycle 3 of DEBOUNCE -> no pulse before rst; D=0 during rst; key_valid 6 edges after rst deassertion with D=10'b0000100000.
